// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: types and helpers shared by the load/store unit and the control FSM.
//  - lsu_err_e   : response error codes
//  - lsu_state_e : LSU sequencing states
//  - F3_*        : RV32I funct3 size/sign encodings
//  - lsu_check   : alignment / legality check applied at request accept
//  - lsu_be      : byte-lane enables for a size and byte offset
//  - lsu_wlanes  : store data replicated across byte lanes
package rv_lsu_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } lsu_err_e;

  typedef enum logic [2:0] {
    S_IDLE, S_BUS, S_RESP, S_TOUT, S_ERR, S_REL
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Illegal encodings take priority over misalignment so a store with a
  // load-only size reports ILLEGAL even at an odd address.
  function automatic lsu_err_e lsu_check(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
    lsu_err_e e;
    e = ERR_OK;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 > F3_W))
      e = ERR_ILLEGAL;
    else if (((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'd0))
      e = ERR_MISALIGN;
    return e;
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] lsu_wlanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {4{d[7:0]}};
      F3_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// rv_load_align: combinational load-data extraction.
//  funct3 : size/sign of the load
//  lane   : byte offset within the word (addr[1:0])
//  din    : raw 32-bit bus word
//  rdata  : right-justified, sign- or zero-extended result
module rv_load_align
  import rv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] din,
  output logic [31:0] rdata
);

  logic [31:0] sh;

  // Bring the addressed lane down to bit 0 before extending.
  assign sh = din >> {lane, 3'b000};

  always_comb begin
    rdata = sh;
    case (funct3)
      F3_B:    rdata = {{24{sh[7]}}, sh[7:0]};
      F3_H:    rdata = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   rdata = {24'd0, sh[7:0]};
      F3_HU:   rdata = {16'd0, sh[15:0]};
      default: rdata = sh;
    endcase
  end

endmodule

// File: rtl/rv_lsu_bus_master.sv
// rv_lsu_bus_master: single-request load/store unit driving an AS_L/WE_L/DTAck bus.
//  clk, rst_n (synchronous, active-low)
//  req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request from control FSM
//  rsp_valid/rsp_rdata/rsp_err : one-cycle completion pulse with load data / error code
//  bus_as_l/bus_we_l/bus_be/bus_addr/bus_dout : bus master outputs
//  bus_din/bus_dtack : bus slave returns
// Parameters: ADDR_W word-address width, TIMEOUT dtack wait limit (0 = none),
//  ACK_RELEASE wait for dtack to drop before returning to idle.
module rv_lsu_bus_master
  import rv_lsu_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int TIMEOUT     = 255,
  parameter int ACK_RELEASE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              bus_as_l,
  output logic              bus_we_l,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_dout,
  input  logic [31:0]       bus_din,
  input  logic              bus_dtack
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e  state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  lsu_err_e    err_q;
  logic [31:0] rdata_q;
  logic [TW-1:0] cnt;

  logic        accept;
  lsu_err_e    chk;
  logic        tout_hit;
  logic [31:0] aligned;
  logic        unused_addr;

  assign accept   = req_valid && (state == S_IDLE);
  assign chk      = lsu_check(req_we, req_funct3, req_addr[1:0]);
  // The cycle that would be the TIMEOUT-th without dtack ends the wait.
  assign tout_hit = (TIMEOUT != 0) && (cnt == T_LAST);
  // Upper byte-address bits beyond the bus width are deliberately dropped.
  assign unused_addr = ^addr_q;

  rv_load_align u_align (
    .funct3 (f3_q),
    .lane   (addr_q[1:0]),
    .din    (bus_din),
    .rdata  (aligned)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_valid) state_nx = (chk == ERR_OK) ? S_BUS : S_ERR;
      S_BUS: begin
        if (bus_dtack)     state_nx = S_RESP;
        else if (tout_hit) state_nx = S_TOUT;
      end
      S_RESP, S_TOUT, S_ERR: state_nx = (ACK_RELEASE != 0) ? S_REL : S_IDLE;
      S_REL:  if (!bus_dtack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture, timeout counter, load data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= ERR_OK;
      rdata_q <= 32'd0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= chk;
        cnt     <= '0;
      end else if (state == S_BUS) begin
        if (bus_dtack) rdata_q <= we_q ? 32'd0 : aligned;
        else           cnt     <= cnt + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = ERR_OK;
    bus_as_l  = 1'b1;
    bus_we_l  = 1'b1;
    bus_be    = 4'd0;
    bus_addr  = '0;
    bus_dout  = 32'd0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_BUS: begin
        bus_as_l = 1'b0;
        bus_we_l = ~we_q;
        bus_be   = lsu_be(f3_q, addr_q[1:0]);
        bus_addr = addr_q[ADDR_W+1:2];
        bus_dout = lsu_wlanes(f3_q, wdata_q);
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
      end
      S_TOUT: begin
        rsp_valid = 1'b1;
        rsp_err   = ERR_TIMEOUT;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
